// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Pipeline hazard controller for the 5-stage MIPS core. Generates the stall,
// bubble and flush controls that sit around the operand-forwarding path:
//   - load-use hazards that forwarding cannot cover (one-cycle stall + bubble)
//   - taken-branch flushes of IF/ID and ID/EX (no stall)
//   - front-end hold while an iterative mul/div occupies EX
// A saturating counter reports the number of cycles with pc_write low.
//
// Optional feature macro: MULDIV_STALL_EN
//   defined     : MULDIV state, down-counter and mul/div hold logic present
//   not defined : muldiv_start_IDEX ignored, FSM permanently RUN,
//                 muldiv_busy=0, idex_write=1, exmem_flush=0
//
// Parameters:
//   MULDIV_CYCLES     total cycles a mul/div occupies EX (2..16)
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   rs_IFID, rt_IFID      source fields of the instruction in decode
//   uses_rt_IFID          decode instruction reads rt as a source
//   rt_IDEX               load destination of the instruction in EX
//   mem_read_IDEX         instruction in EX is a load
//   branch_taken_EX       branch/jump in EX resolved taken
//   muldiv_start_IDEX     instruction in EX is mult/div
//   stall_clr             synchronous clear of stall_count
//   pc_write, ifid_write, idex_write     register load enables
//   ifid_flush, idex_flush, exmem_flush  bubble/NOP insertion
//   muldiv_busy           FSM in MULDIV
//   stall_count           saturating count of cycles with pc_write=0
// ---------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_IFID,
  input  logic [4:0]  rt_IFID,
  input  logic        uses_rt_IFID,
  input  logic [4:0]  rt_IDEX,
  input  logic        mem_read_IDEX,
  input  logic        branch_taken_EX,
  input  logic        muldiv_start_IDEX,
  input  logic        stall_clr,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        muldiv_busy,
  output logic [15:0] stall_count
);

  logic        load_use_s;
  logic [15:0] stall_count_r;

  // Register 0 is hard-wired zero, so a load into it never creates a hazard.
  assign load_use_s = mem_read_IDEX && (rt_IDEX != 5'd0) &&
                      ((rt_IDEX == rs_IFID) ||
                       (uses_rt_IFID && (rt_IDEX == rt_IFID)));

`ifdef MULDIV_STALL_EN
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    MULDIV = 1'b1
  } state_t;

  // The entry cycle already counts as one hold cycle, hence the -2.
  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 2);

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] cnt_r;
  logic [3:0] next_cnt_s;

  // State and mul/div down-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
    end
  end

  // Next-state and hazard control outputs, RUN priority: branch > mul/div > load-use.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    case (state_r)
      RUN: begin
        if (branch_taken_EX) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (muldiv_start_IDEX) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_flush  = 1'b1;
          next_state_s = MULDIV;
          next_cnt_s   = CNT_LOAD;
        end else if (load_use_s) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end else begin
          pc_write = 1'b1;
        end
      end
      MULDIV: begin
        if (cnt_r != 4'd0) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_flush = 1'b1;
          next_cnt_s  = cnt_r - 4'd1;
        end else begin
          next_state_s = RUN;
        end
      end
      default: begin
        next_state_s = RUN;
        next_cnt_s   = 4'd0;
      end
    endcase
  end

  assign muldiv_busy = (state_r == MULDIV);
`else
  localparam int unused_cycles_p = MULDIV_CYCLES;
  logic unused_start_s;
  assign unused_start_s = muldiv_start_IDEX;

  // Hazard control outputs without mul/div support: branch > load-use.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (branch_taken_EX) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use_s) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else begin
      pc_write = 1'b1;
    end
  end

  assign muldiv_busy = 1'b0;
`endif

  // Saturating stall-cycle counter; clear takes precedence over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= 16'd0;
    end else if (stall_clr) begin
      stall_count_r <= 16'd0;
    end else if (!pc_write && (stall_count_r != 16'hFFFF)) begin
      stall_count_r <= stall_count_r + 16'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Self-checking bench: directed sequences with literal expectations, then
// randomized stimulus. A behavioural model tracks mul/div occupancy as an
// age since entry and the stall count as a plain integer; one compare
// process checks every output on every falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

  localparam int MC = 4;
`ifdef MULDIV_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs_IFID = 5'd0;
  logic [4:0]  rt_IFID = 5'd0;
  logic        uses_rt_IFID = 1'b0;
  logic [4:0]  rt_IDEX = 5'd0;
  logic        mem_read_IDEX = 1'b0;
  logic        branch_taken_EX = 1'b0;
  logic        muldiv_start_IDEX = 1'b0;
  logic        stall_clr = 1'b0;
  logic        pc_write, ifid_write, idex_write;
  logic        ifid_flush, idex_flush, exmem_flush, muldiv_busy;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  hazard_control_unit #(.MULDIV_CYCLES(MC)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rs_IFID           (rs_IFID),
    .rt_IFID           (rt_IFID),
    .uses_rt_IFID      (uses_rt_IFID),
    .rt_IDEX           (rt_IDEX),
    .mem_read_IDEX     (mem_read_IDEX),
    .branch_taken_EX   (branch_taken_EX),
    .muldiv_start_IDEX (muldiv_start_IDEX),
    .stall_clr         (stall_clr),
    .pc_write          (pc_write),
    .ifid_write        (ifid_write),
    .idex_write        (idex_write),
    .ifid_flush        (ifid_flush),
    .idex_flush        (idex_flush),
    .exmem_flush       (exmem_flush),
    .muldiv_busy       (muldiv_busy),
    .stall_count       (stall_count)
  );

  always #5 clk = ~clk;

  // Model state: m_age = -1 when no mul/div is in flight, otherwise the
  // number of cycles since the entry cycle (entry cycle itself is age 0).
  int m_age = -1;
  int m_cnt = 0;

  // Compare process: expectation from the model, then advance the model.
  always @(negedge clk) begin
    logic       lu;
    logic [6:0] exp_v;
    logic [6:0] act_v;
    if (!rst_n) begin
      m_age = -1;
      m_cnt = 0;
    end
    lu = mem_read_IDEX && (rt_IDEX != 5'd0) &&
         ((rt_IDEX == rs_IFID) || (uses_rt_IFID && (rt_IDEX == rt_IFID)));
    // {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, busy}
    if (m_age >= 1) begin
      if (m_age < MC - 1) exp_v = 7'b0000011;
      else                exp_v = 7'b1110001;
    end else if (branch_taken_EX) begin
      exp_v = 7'b1111100;
    end else if (MD_EN && muldiv_start_IDEX) begin
      exp_v = 7'b0000010;
    end else if (lu) begin
      exp_v = 7'b0010100;
    end else begin
      exp_v = 7'b1110000;
    end
    act_v = {pc_write, ifid_write, idex_write, ifid_flush, idex_flush,
             exmem_flush, muldiv_busy};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_ctrl t=%0t got %b expected %b", $time, act_v, exp_v);
    end
    checks++;
    if (stall_count !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL model_stall_count t=%0t got %0d expected %0d",
               $time, stall_count, m_cnt);
    end
    if (rst_n) begin
      if (m_age >= 1) m_age = (m_age < MC - 1) ? m_age + 1 : -1;
      else if (!branch_taken_EX && MD_EN && muldiv_start_IDEX) m_age = 1;
      if (stall_clr) m_cnt = 0;
      else if (!exp_v[6] && m_cnt < 65535) m_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic clr_in();
    rs_IFID = 5'd0; rt_IFID = 5'd0; uses_rt_IFID = 1'b0; rt_IDEX = 5'd0;
    mem_read_IDEX = 1'b0; branch_taken_EX = 1'b0; muldiv_start_IDEX = 1'b0;
    stall_clr = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    rst_n = 1'b0;
    repeat (2) cyc();
    at_neg();
    chk("reset_pc_write", int'(pc_write), 1);
    chk("reset_idex_write", int'(idex_write), 1);
    chk("reset_exmem_flush", int'(exmem_flush), 0);
    chk("reset_busy", int'(muldiv_busy), 0);
    chk("reset_stall_count", int'(stall_count), 0);
    cyc(); rst_n = 1'b1;

    // Load-use via rs
    cyc(); mem_read_IDEX = 1'b1; rt_IDEX = 5'd8; rs_IFID = 5'd8;
    at_neg();
    chk("lu_pc_write", int'(pc_write), 0);
    chk("lu_ifid_write", int'(ifid_write), 0);
    chk("lu_idex_flush", int'(idex_flush), 1);
    cyc(); clr_in();
    at_neg();
    chk("lu_stall_count", int'(stall_count), 1);
    chk("lu_released", int'(pc_write), 1);

    // rt path
    cyc(); mem_read_IDEX = 1'b1; rt_IDEX = 5'd9; rt_IFID = 5'd9; rs_IFID = 5'd1;
    at_neg();
    chk("rt_unused_no_stall", int'(pc_write), 1);
    cyc(); uses_rt_IFID = 1'b1;
    at_neg();
    chk("rt_used_stall", int'(pc_write), 0);
    cyc(); rt_IDEX = 5'd0; rt_IFID = 5'd0; rs_IFID = 5'd0;
    at_neg();
    chk("rt_zero_no_stall", int'(pc_write), 1);
    cyc(); clr_in();
    at_neg();
    chk("rt_stall_count", int'(stall_count), 2);

    // Branch beats load-use
    cyc(); mem_read_IDEX = 1'b1; rt_IDEX = 5'd8; rs_IFID = 5'd8; branch_taken_EX = 1'b1;
    at_neg();
    chk("prio_pc_write", int'(pc_write), 1);
    chk("prio_ifid_flush", int'(ifid_flush), 1);
    chk("prio_idex_flush", int'(idex_flush), 1);
    cyc(); clr_in();
    at_neg();
    chk("prio_stall_count", int'(stall_count), 2);

    // Mul/div with start held through the release cycle
    cyc(); stall_clr = 1'b1;
    cyc(); stall_clr = 1'b0; muldiv_start_IDEX = 1'b1;
    for (int k = 0; k < MC; k++) begin
      if (k > 0) cyc();
      at_neg();
      if (MD_EN) begin
        chk("md_pc_write", int'(pc_write), (k < MC - 1) ? 0 : 1);
        chk("md_idex_write", int'(idex_write), (k < MC - 1) ? 0 : 1);
        chk("md_exmem_flush", int'(exmem_flush), (k < MC - 1) ? 1 : 0);
        chk("md_busy", int'(muldiv_busy), (k >= 1) ? 1 : 0);
      end else begin
        chk("nomd_pc_write", int'(pc_write), 1);
        chk("nomd_idex_write", int'(idex_write), 1);
        chk("nomd_exmem_flush", int'(exmem_flush), 0);
        chk("nomd_busy", int'(muldiv_busy), 0);
      end
    end
    cyc(); clr_in();
    at_neg();
    chk("md_stall_count", int'(stall_count), MD_EN ? MC - 1 : 0);
    chk("md_back_to_run", int'(muldiv_busy), 0);

    // Reset during the second MULDIV cycle
    cyc(); muldiv_start_IDEX = 1'b1;
    cyc(); muldiv_start_IDEX = 1'b0;
    cyc(); rst_n = 1'b0;
    at_neg();
    chk("rst_mid_busy", int'(muldiv_busy), 0);
    chk("rst_mid_pc_write", int'(pc_write), 1);
    chk("rst_mid_stall_count", int'(stall_count), 0);
    cyc(); rst_n = 1'b1;

    // Saturation, then clear racing a stall
    cyc(); mem_read_IDEX = 1'b1; rt_IDEX = 5'd8; rs_IFID = 5'd8;
    repeat (65540) cyc();
    at_neg();
    chk("sat_stall_count", int'(stall_count), 65535);
    cyc(); stall_clr = 1'b1;
    at_neg();
    chk("sat_clr_with_stall", int'(pc_write), 0);
    cyc(); clr_in();
    at_neg();
    chk("sat_cleared", int'(stall_count), 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc();
      rs_IFID           = 5'($urandom_range(0, 3));
      rt_IFID           = 5'($urandom_range(0, 3));
      rt_IDEX           = 5'($urandom_range(0, 3));
      uses_rt_IFID      = 1'($urandom_range(0, 1));
      mem_read_IDEX     = 1'($urandom_range(0, 1));
      branch_taken_EX   = ($urandom_range(0, 7) == 0);
      muldiv_start_IDEX = ($urandom_range(0, 9) == 0);
      stall_clr         = ($urandom_range(0, 63) == 0);
      rst_n             = ($urandom_range(0, 299) != 0);
    end
    cyc(); clr_in(); rst_n = 1'b1;
    at_neg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
